// File: rtl/core_cmt.sv
// core_cmt: in-order commit buffer ahead of the architectural register file.
// Tags are handed out at dispatch, results arrive out of order on CMPL ports,
// and entries retire strictly in program order through one registered write port.
module core_cmt #(
    parameter  int DEPTH = 8,
    parameter  int CMPL  = 2,
    localparam int TW    = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 alloc_valid_i,
    output logic                 alloc_ready_o,
    input  logic                 alloc_wen_i,
    input  logic [3:0]           alloc_addr_i,
    output logic [TW-1:0]        alloc_tag_o,
    input  logic [CMPL-1:0]      cmpl_valid_i,
    input  logic [CMPL*TW-1:0]   cmpl_tag_i,
    input  logic [CMPL*16-1:0]   cmpl_data_i,
    input  logic                 flush_i,
    output logic                 wb_en_o,
    output logic [3:0]           wb_addr_o,
    output logic [15:0]          wb_data_o,
    output logic                 retire_o,
    output logic [TW:0]          count_o,
    output logic                 empty_o,
    output logic                 cmpl_err_o
);

    typedef enum logic [1:0] {S_FREE, S_WAIT, S_DONE} ent_st_t;

    ent_st_t       st_q   [DEPTH];
    logic          wen_q  [DEPTH];
    logic [3:0]    addr_q [DEPTH];
    logic [15:0]   data_q [DEPTH];

    logic [TW-1:0] head_q;
    logic [TW-1:0] tail_q;
    logic [TW:0]   count_q;
    logic          err_q;
    logic          wb_en_q;
    logic          retire_q;
    logic [3:0]    wb_addr_q;
    logic [15:0]   wb_data_q;

    logic              alloc_acc;
    logic              commit;
    logic              err_now;
    logic [DEPTH-1:0]  cmpl_hit;
    logic [15:0]       cmpl_wdata [DEPTH];
    logic [TW-1:0]     tg;
    logic              dup;

    // Full is judged from the registered count only, so a commit never frees a slot the same cycle.
    assign alloc_acc = alloc_valid_i && (count_q != (TW+1)'(DEPTH));
    // Commit looks at registered state, so a result reaches the register file one edge after capture.
    assign commit    = (st_q[head_q] == S_DONE);

    // Resolve completion ports: legal hits only on WAIT entries, lowest port wins a shared tag.
    always_comb begin
        cmpl_hit = '0;
        err_now  = 1'b0;
        tg       = '0;
        dup      = 1'b0;
        for (int i = 0; i < DEPTH; i++) cmpl_wdata[i] = '0;
        for (int p = 0; p < CMPL; p++) begin
            tg  = cmpl_tag_i[p*TW +: TW];
            dup = 1'b0;
            for (int q = 0; q < p; q++) begin
                if (cmpl_valid_i[q] && (cmpl_tag_i[q*TW +: TW] == tg)) dup = 1'b1;
            end
            if (cmpl_valid_i[p]) begin
                if (dup || (st_q[tg] != S_WAIT)) begin
                    err_now = 1'b1;
                end else begin
                    cmpl_hit[tg]   = 1'b1;
                    cmpl_wdata[tg] = cmpl_data_i[p*16 +: 16];
                end
            end
        end
    end

    // Control state: entry states, pointers, count, retire strobes and the sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= S_FREE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_en_q  <= 1'b0;
            retire_q <= 1'b0;
            err_q    <= 1'b0;
        end else if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) st_q[i] <= S_FREE;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            wb_en_q  <= 1'b0;
            retire_q <= 1'b0;
        end else begin
            if (err_now) err_q <= 1'b1;
            // Hit, head and tail entries are always distinct (WAIT, DONE, FREE respectively).
            for (int i = 0; i < DEPTH; i++) begin
                if (cmpl_hit[i]) st_q[i] <= S_DONE;
            end
            if (commit) begin
                st_q[head_q] <= S_FREE;
                head_q       <= head_q + TW'(1);
            end
            if (alloc_acc) begin
                st_q[tail_q] <= S_WAIT;
                tail_q       <= tail_q + TW'(1);
            end
            count_q  <= count_q + (TW+1)'(alloc_acc) - (TW+1)'(commit);
            wb_en_q  <= commit && wen_q[head_q];
            retire_q <= commit;
        end
    end

    // Register-file address/data hold between commits; only reset clears them.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (!flush_i && commit) begin
            wb_addr_q <= addr_q[head_q];
            wb_data_q <= data_q[head_q];
        end
    end

    // Entry payload storage; the entry state decides whether its contents mean anything.
    always_ff @(posedge clk_i) begin
        if (!flush_i && alloc_acc) begin
            wen_q[tail_q]  <= alloc_wen_i;
            addr_q[tail_q] <= alloc_addr_i;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!flush_i && cmpl_hit[i]) data_q[i] <= cmpl_wdata[i];
        end
    end

    assign alloc_ready_o = (count_q != (TW+1)'(DEPTH));
    assign alloc_tag_o   = tail_q;
    assign count_o       = count_q;
    assign empty_o       = (count_q == '0);
    assign wb_en_o       = wb_en_q;
    assign wb_addr_o     = wb_addr_q;
    assign wb_data_o     = wb_data_q;
    assign retire_o      = retire_q;
    assign cmpl_err_o    = err_q;

endmodule

// File: tb/tb_core_cmt.sv
// tb_core_cmt: directed scenarios plus randomized traffic for the commit buffer,
// checked against a program-order queue model of the buffer contents.
module tb_core_cmt;

    localparam int DEPTH = 8;
    localparam int CMPL  = 2;
    localparam int TW    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               alloc_valid;
    logic               alloc_ready;
    logic               alloc_wen;
    logic [3:0]         alloc_addr;
    logic [TW-1:0]      alloc_tag;
    logic [CMPL-1:0]    cmpl_valid;
    logic [CMPL*TW-1:0] cmpl_tag;
    logic [CMPL*16-1:0] cmpl_data;
    logic               flush;
    logic               wb_en;
    logic [3:0]         wb_addr;
    logic [15:0]        wb_data;
    logic               retire;
    logic [TW:0]        count;
    logic               empty;
    logic               cmpl_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    core_cmt #(.DEPTH(DEPTH), .CMPL(CMPL)) dut (
        .clk_i(clk), .rst_i(rst),
        .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready),
        .alloc_wen_i(alloc_wen), .alloc_addr_i(alloc_addr), .alloc_tag_o(alloc_tag),
        .cmpl_valid_i(cmpl_valid), .cmpl_tag_i(cmpl_tag), .cmpl_data_i(cmpl_data),
        .flush_i(flush),
        .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
        .retire_o(retire), .count_o(count), .empty_o(empty), .cmpl_err_o(cmpl_err)
    );

    // Reference model: instructions in program order, oldest at index 0.
    typedef struct {
        logic [TW-1:0] tag;
        logic          wen;
        logic [3:0]    addr;
        logic [15:0]   data;
        bit            done;
    } ent_t;

    ent_t        mq[$];
    int          m_next = 0;
    bit          m_err = 0;
    logic        m_wb_en = 0;
    logic        m_ret = 0;
    logic [3:0]  m_wb_addr = 0;
    logic [15:0] m_wb_data = 0;

    task automatic idle();
        rst = 0; alloc_valid = 0; alloc_wen = 0; alloc_addr = 0;
        cmpl_valid = 0; cmpl_tag = 0; cmpl_data = 0; flush = 0;
    endtask

    task automatic set_cmpl(input int p, input int tag, input logic [15:0] d);
        cmpl_valid[p]             = 1'b1;
        cmpl_tag[p*TW +: TW]      = TW'(tag);
        cmpl_data[p*16 +: 16]     = d;
    endtask

    // One clock edge; the model consumes the same inputs the DUT sampled.
    task automatic step();
        bit do_commit, do_alloc, dup;
        int idx;
        logic [TW-1:0] t;
        ent_t e;
        @(posedge clk);
        if (rst) begin
            mq.delete(); m_next = 0; m_err = 0; m_wb_en = 0; m_ret = 0;
            m_wb_addr = 0; m_wb_data = 0;
        end else if (flush) begin
            mq.delete(); m_next = 0; m_wb_en = 0; m_ret = 0;
        end else begin
            do_commit = (mq.size() > 0) && mq[0].done;
            do_alloc  = alloc_valid && (mq.size() < DEPTH);
            for (int p = 0; p < CMPL; p++) begin
                if (cmpl_valid[p]) begin
                    t = cmpl_tag[p*TW +: TW];
                    dup = 0;
                    for (int q = 0; q < p; q++)
                        if (cmpl_valid[q] && cmpl_tag[q*TW +: TW] == t) dup = 1;
                    idx = -1;
                    for (int k = 0; k < mq.size(); k++)
                        if (mq[k].tag == t) idx = k;
                    if (dup || idx < 0) m_err = 1;
                    else if (mq[idx].done) m_err = 1;
                    else begin
                        e = mq[idx]; e.done = 1; e.data = cmpl_data[p*16 +: 16]; mq[idx] = e;
                    end
                end
            end
            if (do_commit) begin
                m_wb_en = mq[0].wen; m_wb_addr = mq[0].addr; m_wb_data = mq[0].data;
                m_ret = 1; void'(mq.pop_front());
            end else begin
                m_wb_en = 0; m_ret = 0;
            end
            if (do_alloc) begin
                e.tag = TW'(m_next); e.wen = alloc_wen; e.addr = alloc_addr;
                e.data = 0; e.done = 0;
                mq.push_back(e);
                m_next = (m_next + 1) % DEPTH;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; step(); step();
        total++; if (count !== 0)     begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        total++; if (empty !== 1)     begin bad++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        total++; if (alloc_ready !== 1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", alloc_ready); end
        total++; if (alloc_tag !== 0) begin bad++; $display("FAIL reset_tag got=%0d exp=0", alloc_tag); end
        total++; if (wb_en !== 0 || retire !== 0) begin bad++; $display("FAIL reset_wb got=%0b/%0b exp=0/0", wb_en, retire); end
        total++; if (wb_addr !== 0 || wb_data !== 0) begin bad++; $display("FAIL reset_wbdata got=%0h/%0h exp=0/0", wb_addr, wb_data); end
        total++; if (cmpl_err !== 0)  begin bad++; $display("FAIL reset_err got=%0b exp=0", cmpl_err); end
        rst = 0;
    endtask

    task automatic test_in_order();
        idle(); alloc_valid = 1; alloc_wen = 1;
        for (int i = 0; i < 3; i++) begin
            alloc_addr = 4'(i + 1);
            total++; if (alloc_tag !== TW'(i)) begin bad++; $display("FAIL order_tag got=%0d exp=%0d", alloc_tag, i); end
            step();
        end
        alloc_valid = 0;
        set_cmpl(0, 2, 16'h0003); step();
        total++; if (wb_en !== 0) begin bad++; $display("FAIL order_early1 got=%0b exp=0", wb_en); end
        cmpl_valid = 0; set_cmpl(0, 0, 16'h0001); step();
        total++; if (wb_en !== 0) begin bad++; $display("FAIL order_early2 got=%0b exp=0", wb_en); end
        cmpl_valid = 0; set_cmpl(1, 1, 16'h0002); step();
        total++; if (wb_en !== 1 || wb_addr !== 4'd1 || wb_data !== 16'h0001)
            begin bad++; $display("FAIL order_r1 got=%0b/%0h/%0h exp=1/1/0001", wb_en, wb_addr, wb_data); end
        idle(); step();
        total++; if (wb_en !== 1 || wb_addr !== 4'd2 || wb_data !== 16'h0002)
            begin bad++; $display("FAIL order_r2 got=%0b/%0h/%0h exp=1/2/0002", wb_en, wb_addr, wb_data); end
        step();
        total++; if (wb_en !== 1 || wb_addr !== 4'd3 || wb_data !== 16'h0003)
            begin bad++; $display("FAIL order_r3 got=%0b/%0h/%0h exp=1/3/0003", wb_en, wb_addr, wb_data); end
        step();
        total++; if (wb_en !== 0 || empty !== 1)
            begin bad++; $display("FAIL order_drain got=%0b/%0b exp=0/1", wb_en, empty); end
    endtask

    task automatic test_full_wrap();
        idle(); flush = 1; step(); flush = 0;
        alloc_valid = 1; alloc_wen = 1;
        for (int i = 0; i < DEPTH; i++) begin alloc_addr = 4'(i); step(); end
        alloc_valid = 0;
        total++; if (count !== 4'd8 || alloc_ready !== 0)
            begin bad++; $display("FAIL full_state got=%0d/%0b exp=8/0", count, alloc_ready); end
        set_cmpl(0, 0, 16'h00F0); step();
        cmpl_valid = 0; alloc_valid = 1; alloc_addr = 4'hE;
        total++; if (alloc_ready !== 0) begin bad++; $display("FAIL full_ready_pre got=%0b exp=0", alloc_ready); end
        step();
        total++; if (retire !== 1 || wb_data !== 16'h00F0)
            begin bad++; $display("FAIL full_commit got=%0b/%0h exp=1/00f0", retire, wb_data); end
        total++; if (count !== 4'd7) begin bad++; $display("FAIL full_reject got=%0d exp=7", count); end
        total++; if (alloc_ready !== 1 || alloc_tag !== 0)
            begin bad++; $display("FAIL full_wrap got=%0b/%0d exp=1/0", alloc_ready, alloc_tag); end
        step(); alloc_valid = 0;
        total++; if (count !== 4'd8 || alloc_tag !== 1)
            begin bad++; $display("FAIL full_refill got=%0d/%0d exp=8/1", count, alloc_tag); end
    endtask

    task automatic test_no_wen();
        idle(); flush = 1; step(); flush = 0;
        alloc_valid = 1; alloc_wen = 0; alloc_addr = 4'd5; step();
        alloc_valid = 0; set_cmpl(1, 0, 16'h1234); step();
        cmpl_valid = 0; step();
        total++; if (retire !== 1 || wb_en !== 0)
            begin bad++; $display("FAIL nowen_strobe got=%0b/%0b exp=1/0", retire, wb_en); end
        total++; if (count !== 0 || empty !== 1 || alloc_tag !== 1)
            begin bad++; $display("FAIL nowen_head got=%0d/%0b/%0d exp=0/1/1", count, empty, alloc_tag); end
    endtask

    task automatic test_errors();
        idle(); rst = 1; step(); rst = 0;
        alloc_valid = 1; alloc_wen = 1; alloc_addr = 4'd7; step();
        alloc_valid = 0; set_cmpl(0, 0, 16'hAAAA); set_cmpl(1, 0, 16'h5555); step();
        total++; if (cmpl_err !== 1) begin bad++; $display("FAIL dup_err got=%0b exp=1", cmpl_err); end
        idle(); step();
        total++; if (wb_en !== 1 || wb_addr !== 4'd7 || wb_data !== 16'hAAAA)
            begin bad++; $display("FAIL dup_win got=%0b/%0h/%0h exp=1/7/aaaa", wb_en, wb_addr, wb_data); end
        flush = 1; step(); flush = 0;
        total++; if (cmpl_err !== 1) begin bad++; $display("FAIL flush_keeps_err got=%0b exp=1", cmpl_err); end
        rst = 1; step(); rst = 0;
        total++; if (cmpl_err !== 0) begin bad++; $display("FAIL err_clear got=%0b exp=0", cmpl_err); end
        set_cmpl(0, 3, 16'h0BAD); step(); idle();
        total++; if (cmpl_err !== 1) begin bad++; $display("FAIL free_err got=%0b exp=1", cmpl_err); end
    endtask

    task automatic test_flush();
        idle(); rst = 1; step(); rst = 0;
        alloc_valid = 1; alloc_wen = 1;
        for (int i = 0; i < 5; i++) begin alloc_addr = 4'(i + 8); step(); end
        alloc_valid = 0; set_cmpl(0, 0, 16'h1111); set_cmpl(1, 2, 16'h2222); step();
        cmpl_valid = 0; flush = 1; step(); flush = 0;
        total++; if (count !== 0 || empty !== 1 || alloc_tag !== 0)
            begin bad++; $display("FAIL flush_state got=%0d/%0b/%0d exp=0/1/0", count, empty, alloc_tag); end
        total++; if (wb_en !== 0 || retire !== 0)
            begin bad++; $display("FAIL flush_wb got=%0b/%0b exp=0/0", wb_en, retire); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (wb_en !== 0 || retire !== 0)
                begin bad++; $display("FAIL flush_nowrite got=%0b/%0b exp=0/0", wb_en, retire); end
        end
        alloc_valid = 1; step(); alloc_valid = 0;
        total++; if (count !== 1 || alloc_tag !== 1)
            begin bad++; $display("FAIL flush_realloc got=%0d/%0d exp=1/1", count, alloc_tag); end
    endtask

    task automatic test_stream();
        logic [19:0] sb[$];
        logic [3:0]  addrs[20];
        logic [15:0] d;
        int nwr;
        nwr = 0;
        idle(); rst = 1; step(); rst = 0;
        for (int k = 0; k < 23; k++) begin
            idle();
            if (k < 20) begin
                alloc_valid = 1; alloc_wen = 1;
                addrs[k] = 4'($urandom_range(15)); alloc_addr = addrs[k];
            end
            if (k >= 1 && k <= 20) begin
                d = 16'($urandom);
                set_cmpl(0, (k - 1) % DEPTH, d);
                sb.push_back({addrs[k-1], d});
            end
            step();
            if (k >= 1 && k <= 19) begin
                total++; if (count !== 2) begin bad++; $display("FAIL stream_count k=%0d got=%0d exp=2", k, count); end
            end
            if (k >= 2 && k <= 21) begin
                total++;
                if (wb_en !== 1 || sb.size() == 0) begin
                    bad++; $display("FAIL stream_rate k=%0d got=%0b exp=1", k, wb_en);
                end else if ({wb_addr, wb_data} !== sb[0]) begin
                    bad++; $display("FAIL stream_data k=%0d got=%0h exp=%0h", k, {wb_addr, wb_data}, sb[0]);
                end
            end
            if (wb_en === 1) begin
                nwr++;
                if (sb.size() > 0) void'(sb.pop_front());
            end
        end
        idle();
        total++; if (nwr !== 20) begin bad++; $display("FAIL stream_writes got=%0d exp=20", nwr); end
    endtask

    task automatic test_random();
        int sz;
        idle(); rst = 1; step(); rst = 0;
        for (int n = 0; n < 400; n++) begin
            idle();
            alloc_valid = ($urandom_range(2) != 0);
            alloc_wen   = $urandom_range(1);
            alloc_addr  = 4'($urandom_range(15));
            for (int p = 0; p < CMPL; p++) begin
                if ($urandom_range(1) == 1) begin
                    sz = mq.size();
                    if (sz > 0 && $urandom_range(3) != 0)
                        set_cmpl(p, int'(mq[$urandom_range(sz - 1)].tag), 16'($urandom));
                    else
                        set_cmpl(p, $urandom_range(DEPTH - 1), 16'($urandom));
                end
            end
            flush = ($urandom_range(39) == 0);
            step();
            total++; if (wb_en !== m_wb_en) begin bad++; $display("FAIL rnd_wb_en n=%0d got=%0b exp=%0b", n, wb_en, m_wb_en); end
            total++; if (retire !== m_ret) begin bad++; $display("FAIL rnd_retire n=%0d got=%0b exp=%0b", n, retire, m_ret); end
            total++; if (wb_addr !== m_wb_addr) begin bad++; $display("FAIL rnd_wb_addr n=%0d got=%0h exp=%0h", n, wb_addr, m_wb_addr); end
            total++; if (wb_data !== m_wb_data) begin bad++; $display("FAIL rnd_wb_data n=%0d got=%0h exp=%0h", n, wb_data, m_wb_data); end
            total++; if (count !== (TW+1)'(mq.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, count, mq.size()); end
            total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%0b exp=%0b", n, empty, mq.size() == 0); end
            total++; if (alloc_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, alloc_ready, mq.size() < DEPTH); end
            total++; if (alloc_tag !== TW'(m_next)) begin bad++; $display("FAIL rnd_tag n=%0d got=%0d exp=%0d", n, alloc_tag, m_next); end
            total++; if (cmpl_err !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, cmpl_err, m_err); end
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_in_order();
        test_full_wrap();
        test_no_wen();
        test_errors();
        test_flush();
        test_stream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
